// File: rtl/ins_fetcher_if.sv
// Fetch-unit bus: instruction-cache handshake, decoder hand-off and ROB flush.
// master = fetcher side, slave = cache/decoder/ROB side.
interface ins_fetcher_if;
  logic        icache_req;
  logic [31:0] icache_addr;
  logic        icache_ready;
  logic [31:0] icache_inst;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] inst_addr;
  logic        dec_stall;
  logic [31:0] dec_next_pc;
  logic        rob_clear;
  logic [31:0] rob_clear_pc;

  modport master (
    output icache_req, icache_addr, inst_valid, inst, inst_addr,
    input  icache_ready, icache_inst, dec_stall, dec_next_pc, rob_clear, rob_clear_pc
  );

  modport slave (
    input  icache_req, icache_addr, inst_valid, inst, inst_addr,
    output icache_ready, icache_inst, dec_stall, dec_next_pc, rob_clear, rob_clear_pc
  );
endinterface

// File: rtl/ins_fetcher.sv
// Instruction fetcher: keeps at most one icache request in flight and presents
// one instruction at a time to the decoder, honouring ROB flushes.
module ins_fetcher #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic          clk_in,
  input  logic          rst_in,
  input  logic          rdy_in,
  ins_fetcher_if.master bus
);
  typedef enum logic [1:0] {
    FETCH   = 2'd0,
    WAIT    = 2'd1,
    PRESENT = 2'd2,
    DISCARD = 2'd3
  } state_t;

  state_t      state_r;
  logic [31:0] pc_r;
  logic [31:0] addr_r;
  logic [31:0] inst_r;
  logic [31:0] inst_addr_r;
  logic        req_r;
  logic        valid_r;

  assign bus.icache_req  = req_r;
  assign bus.icache_addr = addr_r;
  assign bus.inst_valid  = valid_r;
  assign bus.inst        = inst_r;
  assign bus.inst_addr   = inst_addr_r;

  // Fetch FSM with registered outputs; rob_clear outranks every other event.
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      state_r     <= FETCH;
      pc_r        <= RESET_PC;
      addr_r      <= RESET_PC;
      req_r       <= 1'b0;
      valid_r     <= 1'b0;
      inst_r      <= 32'h0000_0000;
      inst_addr_r <= 32'h0000_0000;
    end else if (rdy_in) begin
      case (state_r)
        FETCH: begin
          if (bus.rob_clear) begin
            pc_r    <= bus.rob_clear_pc;
            valid_r <= 1'b0;
          end else begin
            req_r   <= 1'b1;
            addr_r  <= {pc_r[31:2], 2'b00};
            state_r <= WAIT;
          end
        end
        WAIT: begin
          if (bus.rob_clear) begin
            pc_r    <= bus.rob_clear_pc;
            valid_r <= 1'b0;
            if (bus.icache_ready) begin
              req_r   <= 1'b0;
              state_r <= FETCH;
            end else begin
              state_r <= DISCARD;
            end
          end else if (bus.icache_ready) begin
            inst_r      <= bus.icache_inst;
            inst_addr_r <= pc_r;
            valid_r     <= 1'b1;
            req_r       <= 1'b0;
            state_r     <= PRESENT;
          end else begin
            state_r <= WAIT;
          end
        end
        PRESENT: begin
          if (bus.rob_clear) begin
            pc_r    <= bus.rob_clear_pc;
            valid_r <= 1'b0;
            state_r <= FETCH;
          end else if (!bus.dec_stall) begin
            pc_r    <= bus.dec_next_pc;
            valid_r <= 1'b0;
            state_r <= FETCH;
          end else begin
            state_r <= PRESENT;
          end
        end
        DISCARD: begin
          // The stale word still has to drain before a new request may issue.
          if (bus.rob_clear) begin
            pc_r <= bus.rob_clear_pc;
          end else begin
            pc_r <= pc_r;
          end
          valid_r <= 1'b0;
          if (bus.icache_ready) begin
            req_r   <= 1'b0;
            state_r <= FETCH;
          end else begin
            state_r <= DISCARD;
          end
        end
        default: begin
          state_r <= FETCH;
          req_r   <= 1'b0;
          valid_r <= 1'b0;
        end
      endcase
    end else begin
      state_r <= state_r;
    end
  end
endmodule

// File: tb/tb_ins_fetcher.sv
// Self-checking bench for ins_fetcher: scripted cache/decoder/ROB stimulus with
// a scoreboard of expected presented instructions.
module tb_ins_fetcher;
  logic clk = 1'b0;
  logic rst_in;
  logic rdy_in;
  int   total = 0;
  int   bad = 0;

  typedef struct {
    logic [31:0] word;
    logic [31:0] addr;
  } exp_t;
  exp_t sb[$];

  ins_fetcher_if bus ();

  ins_fetcher #(.RESET_PC(32'h0000_0000)) dut (
    .clk_in (clk),
    .rst_in (rst_in),
    .rdy_in (rdy_in),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  task test_reset();
    rst_in = 1'b0;
    rdy_in = 1'b0;
    bus.rob_clear = 1'b1;
    bus.rob_clear_pc = 32'h0000_0999;
    repeat (3) @(negedge clk);
    total++; if (bus.icache_req !== 1'b0) begin bad++; $display("FAIL rst_req got %b want 0", bus.icache_req); end
    total++; if (bus.icache_addr !== 32'h0) begin bad++; $display("FAIL rst_addr got %h want 0", bus.icache_addr); end
    total++; if (bus.inst_valid !== 1'b0) begin bad++; $display("FAIL rst_valid got %b want 0", bus.inst_valid); end
    total++; if (bus.inst !== 32'h0 || bus.inst_addr !== 32'h0) begin bad++; $display("FAIL rst_inst got %h/%h want 0/0", bus.inst, bus.inst_addr); end
    bus.rob_clear = 1'b0;
    rdy_in = 1'b1;
    rst_in = 1'b1;
    @(negedge clk);
    total++; if (bus.icache_req !== 1'b1 || bus.icache_addr !== 32'h0) begin bad++; $display("FAIL first_req got %b/%h want 1/0", bus.icache_req, bus.icache_addr); end
  endtask

  // Wait for a request, hold ready low for lat cycles, then return word.
  task serve(input int lat, input logic [31:0] word, input logic [31:0] a, input bit keep);
    int n = 0;
    while (bus.icache_req !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    total++; if (bus.icache_req !== 1'b1) begin bad++; $display("FAIL serve_req timeout got %b want 1", bus.icache_req); end
    for (int i = 0; i < lat; i++) begin
      total++; if (bus.icache_addr !== a || bus.inst_valid !== 1'b0) begin bad++; $display("FAIL wait_hold got %h/%b want %h/0", bus.icache_addr, bus.inst_valid, a); end
      @(negedge clk);
    end
    total++; if (bus.icache_addr !== a) begin bad++; $display("FAIL serve_addr got %h want %h", bus.icache_addr, a); end
    bus.icache_ready = 1'b1;
    bus.icache_inst = word;
    if (keep) sb.push_back('{word: word, addr: a});
    @(negedge clk);
    bus.icache_ready = 1'b0;
    bus.icache_inst = 32'hDEAD_BEEF;
  endtask

  task check_present();
    exp_t e;
    total++; if (bus.inst_valid !== 1'b1 || bus.icache_req !== 1'b0) begin bad++; $display("FAIL present got valid=%b req=%b want 1/0", bus.inst_valid, bus.icache_req); end
    total++;
    if (sb.size() == 0) begin
      bad++; $display("FAIL sb_empty got size 0 want >0");
    end else begin
      e = sb.pop_front();
      if (bus.inst !== e.word || bus.inst_addr !== e.addr) begin
        bad++; $display("FAIL present_data got %h@%h want %h@%h", bus.inst, bus.inst_addr, e.word, e.addr);
      end
    end
  endtask

  task consume(input logic [31:0] next_pc);
    bus.dec_stall = 1'b0;
    bus.dec_next_pc = next_pc;
    @(negedge clk);
    bus.dec_stall = 1'b1;
    bus.dec_next_pc = 32'h0BAD_0000;
    total++; if (bus.inst_valid !== 1'b0 || bus.icache_req !== 1'b0) begin bad++; $display("FAIL consumed got valid=%b req=%b want 0/0", bus.inst_valid, bus.icache_req); end
    @(negedge clk);
    total++; if (bus.icache_req !== 1'b1 || bus.icache_addr !== next_pc) begin bad++; $display("FAIL next_fetch got %b/%h want 1/%h", bus.icache_req, bus.icache_addr, next_pc); end
  endtask

  task test_basic();
    serve(1, 32'h0000_0013, 32'h0, 1'b1);
    check_present();
    consume(32'h0000_0004);
  endtask

  task test_stall();
    serve(2, 32'hABCD_1234, 32'h4, 1'b1);
    check_present();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      total++;
      if (bus.inst_valid !== 1'b1 || bus.inst !== 32'hABCD_1234 || bus.inst_addr !== 32'h4 || bus.icache_req !== 1'b0) begin
        bad++; $display("FAIL stall_hold got %b %h@%h req=%b want 1 abcd1234@4 req=0", bus.inst_valid, bus.inst, bus.inst_addr, bus.icache_req);
      end
    end
    consume(32'h0000_0100);
  endtask

  task test_wait_clear();
    serve(0, 32'h1111_0000, 32'h100, 1'b1);
    check_present();
    consume(32'h0000_0020);
    bus.rob_clear = 1'b1;
    bus.rob_clear_pc = 32'h0000_0080;
    @(negedge clk);
    bus.rob_clear = 1'b0;
    for (int i = 0; i < 3; i++) begin
      total++; if (bus.icache_req !== 1'b1 || bus.icache_addr !== 32'h20 || bus.inst_valid !== 1'b0) begin bad++; $display("FAIL discard_hold got %b/%h/%b want 1/20/0", bus.icache_req, bus.icache_addr, bus.inst_valid); end
      if (i < 2) @(negedge clk);
    end
    bus.icache_ready = 1'b1;
    bus.icache_inst = 32'h5555_5555;
    @(negedge clk);
    bus.icache_ready = 1'b0;
    total++; if (bus.inst_valid !== 1'b0 || bus.icache_req !== 1'b0) begin bad++; $display("FAIL discard_drop got valid=%b req=%b want 0/0", bus.inst_valid, bus.icache_req); end
    @(negedge clk);
    total++; if (bus.icache_req !== 1'b1 || bus.icache_addr !== 32'h80) begin bad++; $display("FAIL after_discard got %b/%h want 1/80", bus.icache_req, bus.icache_addr); end
  endtask

  task test_present_clear();
    serve(0, 32'h2222_0000, 32'h80, 1'b1);
    check_present();
    bus.dec_stall = 1'b0;
    bus.dec_next_pc = 32'h0000_0040;
    bus.rob_clear = 1'b1;
    bus.rob_clear_pc = 32'h0000_0200;
    @(negedge clk);
    bus.dec_stall = 1'b1;
    bus.rob_clear = 1'b0;
    total++; if (bus.inst_valid !== 1'b0) begin bad++; $display("FAIL pclear_valid got %b want 0", bus.inst_valid); end
    @(negedge clk);
    total++; if (bus.icache_req !== 1'b1 || bus.icache_addr !== 32'h200) begin bad++; $display("FAIL pclear_pc got %b/%h want 1/200", bus.icache_req, bus.icache_addr); end
  endtask

  task test_discard_multi();
    bus.rob_clear = 1'b1;
    bus.rob_clear_pc = 32'h0000_0300;
    @(negedge clk);
    bus.rob_clear_pc = 32'h0000_0400;
    total++; if (bus.icache_req !== 1'b1 || bus.icache_addr !== 32'h200) begin bad++; $display("FAIL multi_hold got %b/%h want 1/200", bus.icache_req, bus.icache_addr); end
    @(negedge clk);
    bus.rob_clear_pc = 32'h0000_0500;
    bus.icache_ready = 1'b1;
    bus.icache_inst = 32'h6666_6666;
    total++; if (bus.icache_addr !== 32'h200 || bus.inst_valid !== 1'b0) begin bad++; $display("FAIL multi_hold2 got %h/%b want 200/0", bus.icache_addr, bus.inst_valid); end
    @(negedge clk);
    bus.rob_clear = 1'b0;
    bus.icache_ready = 1'b0;
    total++; if (bus.icache_req !== 1'b0 || bus.inst_valid !== 1'b0) begin bad++; $display("FAIL multi_drop got %b/%b want 0/0", bus.icache_req, bus.inst_valid); end
    @(negedge clk);
    total++; if (bus.icache_req !== 1'b1 || bus.icache_addr !== 32'h500) begin bad++; $display("FAIL multi_pc got %b/%h want 1/500", bus.icache_req, bus.icache_addr); end
    bus.rob_clear = 1'b1;
    bus.rob_clear_pc = 32'h0000_0600;
    bus.icache_ready = 1'b1;
    bus.icache_inst = 32'h7777_7777;
    @(negedge clk);
    bus.rob_clear = 1'b0;
    bus.icache_ready = 1'b0;
    total++; if (bus.inst_valid !== 1'b0 || bus.icache_req !== 1'b0) begin bad++; $display("FAIL wclr_rdy got %b/%b want 0/0", bus.inst_valid, bus.icache_req); end
    @(negedge clk);
    total++; if (bus.icache_req !== 1'b1 || bus.icache_addr !== 32'h600) begin bad++; $display("FAIL wclr_rdy_pc got %b/%h want 1/600", bus.icache_req, bus.icache_addr); end
  endtask

  task test_freeze();
    rdy_in = 1'b0;
    bus.dec_stall = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      total++; if (bus.icache_req !== 1'b1 || bus.icache_addr !== 32'h600 || bus.inst_valid !== 1'b0) begin bad++; $display("FAIL freeze got %b/%h/%b want 1/600/0", bus.icache_req, bus.icache_addr, bus.inst_valid); end
    end
    bus.dec_stall = 1'b1;
    rdy_in = 1'b1;
    serve(1, 32'h8888_0001, 32'h600, 1'b1);
    check_present();
    consume(32'hFFFF_FFFC);
  endtask

  task test_wrap_and_reset();
    serve(0, 32'h9999_0002, 32'hFFFF_FFFC, 1'b1);
    check_present();
    consume(32'h0000_0000);
    rst_in = 1'b0;
    @(negedge clk);
    total++; if (bus.icache_req !== 1'b0 || bus.icache_addr !== 32'h0 || bus.inst_valid !== 1'b0) begin bad++; $display("FAIL wait_rst got %b/%h/%b want 0/0/0", bus.icache_req, bus.icache_addr, bus.inst_valid); end
    total++; if (bus.inst !== 32'h0 || bus.inst_addr !== 32'h0) begin bad++; $display("FAIL wait_rst_inst got %h/%h want 0/0", bus.inst, bus.inst_addr); end
    rst_in = 1'b1;
    @(negedge clk);
    total++; if (bus.icache_req !== 1'b1 || bus.icache_addr !== 32'h0) begin bad++; $display("FAIL post_rst got %b/%h want 1/0", bus.icache_req, bus.icache_addr); end
  endtask

  initial begin
    bus.icache_ready = 1'b0;
    bus.icache_inst = 32'h0;
    bus.dec_stall = 1'b1;
    bus.dec_next_pc = 32'h0;
    bus.rob_clear = 1'b0;
    bus.rob_clear_pc = 32'h0;
    rst_in = 1'b0;
    rdy_in = 1'b1;
    @(negedge clk);
    test_reset();
    test_basic();
    test_stall();
    test_wait_clear();
    test_present_clear();
    test_discard_multi();
    test_freeze();
    test_wrap_and_reset();
    total++; if (sb.size() != 0) begin bad++; $display("FAIL sb_left got %0d want 0", sb.size()); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
